// File: rtl/mem_arb_pkg.sv
// Shared types and bus command encodings for the memory bus arbiter.
// The BUS_* values match the core's system bus command encoding.
package mem_arb_pkg;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Timeout counter for the arbiter's BUSY phase; expire rises after TIMEOUT_CYC enabled cycles.
module mem_arb_timer #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] count;

  // expire is registered, so the abort decision lands one cycle after count reaches TIMEOUT_CYC-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      expire <= 1'b0;
    end else if (clear) begin
      count  <= '0;
      expire <= 1'b0;
    end else if (enable) begin
      count  <= count + CNT_W'(1);
      expire <= (count == CNT_W'(TIMEOUT_CYC - 1));
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the fetch and load/store ports onto one memory bus, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the data port has fixed priority.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  if_cmd,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_stall,
  input  logic [1:0]  d_cmd,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_stall,
  output logic [1:0]  mem_cmd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        timeout_err
);

  state_t      state;
  owner_t      owner;
  logic        if_req;
  logic        d_req;
  logic        grant_d;
  logic        expire;
  logic [31:0] resp_data;

  assign if_req   = (if_cmd == BUS_LOAD);
  assign d_req    = (d_cmd == BUS_LOAD) || (d_cmd == BUS_STORE);
  assign if_stall = if_req & ~if_ack;
  assign d_stall  = d_req & ~d_ack;

`ifdef MEM_ARB_RR_EN
  owner_t last_grant;

  // On contention, hand the bus to whichever port did not win last time
  always_comb begin
    grant_d = d_req && (!if_req || (last_grant == OWN_IF));
  end
`else
  always_comb begin
    grant_d = d_req;
  end
`endif

  always_comb begin
    resp_data = '0;
    if (mem_ack && (mem_cmd != BUS_STORE)) begin
      resp_data = mem_rdata;
    end
  end

  mem_arb_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == IDLE),
    .enable(state == BUSY),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      mem_cmd     <= BUS_NONE;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      if_ack      <= 1'b0;
      d_ack       <= 1'b0;
      timeout_err <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant  <= OWN_IF;
`endif
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            owner     <= grant_d ? OWN_D : OWN_IF;
            mem_cmd   <= grant_d ? d_cmd : BUS_LOAD;
            mem_addr  <= grant_d ? d_addr : if_addr;
            mem_wdata <= grant_d ? d_wdata : '0;
`ifdef MEM_ARB_RR_EN
            last_grant <= grant_d ? OWN_D : OWN_IF;
`endif
            state     <= BUSY;
          end
        end
        BUSY: begin
          // A real ack wins over a simultaneous timeout
          if (mem_ack || expire) begin
            mem_cmd <= BUS_NONE;
            if (!mem_ack) begin
              timeout_err <= 1'b1;
            end
            if (owner == OWN_D) begin
              d_ack   <= 1'b1;
              d_rdata <= resp_data;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= resp_data;
            end
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
